// File: rtl/pss_peak_selector.sv
// -----------------------------------------------------------------------------
// pss_peak_selector
//
// Purpose:
//   Arbitrates the peak flags of N_DET per-N_id_2 PSS peak detectors that share
//   one sample strobe. The first peak opens a collection window of COLLECT_LEN
//   valid samples. The strongest peak in that window becomes a single decision.
//   The decision carries the winning N_id_2, the sample index of the peak and
//   its score. After the decision, HOLDOFF_LEN valid samples are ignored so
//   that one PSS produces exactly one decision.
//
// Ports:
//   clk_i             clock
//   reset_i           asynchronous, active-high reset
//   s_axis_in_tvalid  sample strobe common to all detectors
//   peak_detected_i   bit k = peak flag of detector k
//   score_i           detector k score at [k*IN_DW +: IN_DW], unsigned
//   valid_o           one-cycle pulse marking a decision
//   N_id_2_o          winning detector index (held until the next decision)
//   sample_idx_o      sample index of the winning peak (held)
//   score_o           winning score (held)
//   busy_o            high whenever the selector is not idle
// -----------------------------------------------------------------------------
module pss_peak_selector #(
    parameter  int IN_DW       = 32,
    parameter  int N_DET       = 3,
    parameter  int COLLECT_LEN = 16,
    parameter  int HOLDOFF_LEN = 64,
    parameter  int CNT_DW      = 32,
    localparam int IDX_W       = (N_DET > 1) ? $clog2(N_DET) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   s_axis_in_tvalid,
    input  logic [N_DET-1:0]       peak_detected_i,
    input  logic [N_DET*IN_DW-1:0] score_i,
    output logic                   valid_o,
    output logic [IDX_W-1:0]       N_id_2_o,
    output logic [CNT_DW-1:0]      sample_idx_o,
    output logic [IN_DW-1:0]       score_o,
    output logic                   busy_o
);

    localparam int WIN_W  = (COLLECT_LEN > 1) ? $clog2(COLLECT_LEN + 1) : 1;
    localparam int HOLD_W = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLDOFF
    } state_t;

    state_t             state, state_n;
    logic [CNT_DW-1:0]  sample_cnt;
    logic [WIN_W-1:0]   win_cnt, win_cnt_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;

    logic [IDX_W-1:0]   best_idx, best_idx_n;
    logic [IN_DW-1:0]   best_score, best_score_n;
    logic [CNT_DW-1:0]  best_sample, best_sample_n;
    logic               decide;

    logic               cand_any;
    logic [IDX_W-1:0]   cand_idx;
    logic [IN_DW-1:0]   cand_score;

    // Per-sample candidate. Scanning upward and replacing only on a strictly
    // greater score makes the lowest detector index win ties.
    always_comb begin
        cand_any   = 1'b0;
        cand_idx   = '0;
        cand_score = '0;
        for (int k = 0; k < N_DET; k++) begin
            if (peak_detected_i[k] &&
                (!cand_any || (score_i[k*IN_DW +: IN_DW] > cand_score))) begin
                cand_any   = 1'b1;
                cand_idx   = IDX_W'(k);
                cand_score = score_i[k*IN_DW +: IN_DW];
            end
        end
    end

    // Next-state logic. Nothing moves on cycles without a sample strobe.
    // win_cnt counts the window samples already taken. The sample that
    // brings the window to COLLECT_LEN is compared first and then decided on.
    always_comb begin
        state_n       = state;
        win_cnt_n     = win_cnt;
        hold_cnt_n    = hold_cnt;
        best_idx_n    = best_idx;
        best_score_n  = best_score;
        best_sample_n = best_sample;
        decide        = 1'b0;

        if (s_axis_in_tvalid) begin
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        best_idx_n    = cand_idx;
                        best_score_n  = cand_score;
                        best_sample_n = sample_cnt;
                        win_cnt_n     = WIN_W'(1);
                        state_n       = COLLECT;
                        if (COLLECT_LEN == 1) begin
                            decide = 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    win_cnt_n = win_cnt + WIN_W'(1);
                    if (cand_any && (cand_score > best_score)) begin
                        best_idx_n    = cand_idx;
                        best_score_n  = cand_score;
                        best_sample_n = sample_cnt;
                    end
                    if (win_cnt == WIN_W'(COLLECT_LEN - 1)) begin
                        decide = 1'b1;
                    end
                end
                HOLDOFF: begin
                    // Peaks are ignored here, including on the last counted sample.
                    if (hold_cnt == HOLD_W'(HOLDOFF_LEN - 1)) begin
                        hold_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        hold_cnt_n = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (decide) begin
            win_cnt_n  = '0;
            hold_cnt_n = '0;
            state_n    = (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
        end
    end

    // State, counters and the registered decision outputs. The outputs take
    // their values from the post-comparison best, so the deciding sample's
    // own peak can still win the window.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            win_cnt      <= '0;
            hold_cnt     <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            best_sample  <= '0;
            valid_o      <= 1'b0;
            N_id_2_o     <= '0;
            sample_idx_o <= '0;
            score_o      <= '0;
            busy_o       <= 1'b0;
        end else begin
            state       <= state_n;
            win_cnt     <= win_cnt_n;
            hold_cnt    <= hold_cnt_n;
            best_idx    <= best_idx_n;
            best_score  <= best_score_n;
            best_sample <= best_sample_n;
            valid_o     <= decide;
            busy_o      <= (state_n != IDLE);
            if (s_axis_in_tvalid) begin
                sample_cnt <= sample_cnt + CNT_DW'(1);
            end
            if (decide) begin
                N_id_2_o     <= best_idx_n;
                sample_idx_o <= best_sample_n;
                score_o      <= best_score_n;
            end
        end
    end

endmodule

// File: tb/tb_pss_peak_selector.sv
// -----------------------------------------------------------------------------
// tb_pss_peak_selector
//
// Purpose:
//   Drives two pss_peak_selector instances with the same stimulus.
//     - Main instance: default parameters.
//     - Narrow instance: CNT_DW=4, COLLECT_LEN=3, HOLDOFF_LEN=0.
//   A reference model tracks absolute sample numbers, the window start and the
//   earliest sample from which peaks may be accepted again. It pushes each
//   expected decision into a per-instance queue. A monitor pops a queue
//   entry whenever its instance pulses valid_o.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_pss_peak_selector;

    logic         clk_i;
    logic         reset_i;
    logic         tvalid;
    logic [2:0]   peak;
    logic [95:0]  score;

    logic         valid0, busy0;
    logic [1:0]   nid0;
    logic [31:0]  idx0, score0;
    logic         valid1, busy1;
    logic [1:0]   nid1;
    logic [3:0]   idx1;
    logic [31:0]  score1;

    typedef struct {
        logic [1:0]  nid;
        logic [31:0] idx;
        logic [31:0] score;
    } dec_t;

    dec_t exp_q0[$];
    dec_t exp_q1[$];
    dec_t last_dec[2];
    bit   fresh[2];

    int tests_run = 0;
    int tests_failed = 0;

    // Model state per instance, in absolute (unwrapped) sample numbers.
    int          coll_len[2] = '{16, 3};
    int          hold_len[2] = '{64, 0};
    int          cnt_dw[2]   = '{32, 4};
    longint      seen[2];
    longint      next_ok[2];
    bit          win_open[2];
    longint      win_start[2];
    logic [1:0]  best_nid[2];
    longint      best_n[2];
    logic [31:0] best_sc[2];

    pss_peak_selector dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tvalid (tvalid),
        .peak_detected_i  (peak),
        .score_i          (score),
        .valid_o          (valid0),
        .N_id_2_o         (nid0),
        .sample_idx_o     (idx0),
        .score_o          (score0),
        .busy_o           (busy0)
    );

    pss_peak_selector #(
        .CNT_DW      (4),
        .COLLECT_LEN (3),
        .HOLDOFF_LEN (0)
    ) dut_w (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tvalid (tvalid),
        .peak_detected_i  (peak),
        .score_i          (score),
        .valid_o          (valid1),
        .N_id_2_o         (nid1),
        .sample_idx_o     (idx1),
        .score_o          (score1),
        .busy_o           (busy1)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            seen[m]     = 0;
            next_ok[m]  = 0;
            win_open[m] = 1'b0;
        end
    endfunction

    function automatic bit model_busy(input int m);
        return win_open[m] || (seen[m] < next_ok[m]);
    endfunction

    function automatic void model_decide(input int m, input longint n);
        dec_t   d;
        longint mask;
        mask  = (64'sd1 <<< cnt_dw[m]) - 1;
        d.nid   = best_nid[m];
        d.idx   = 32'(best_n[m] & mask);
        d.score = best_sc[m];
        if (m == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
        win_open[m] = 1'b0;
        next_ok[m]  = n + 1 + hold_len[m];
    endfunction

    // One valid sample through the model: pick the strongest asserted peak,
    // the lowest detector winning ties. Keep the earliest best in an open
    // window, and decide once the window has spanned COLLECT_LEN samples.
    function automatic void model_step(input int m, input logic [2:0] pk, input logic [95:0] sc);
        int          cn;
        logic [31:0] cs;
        longint      n;
        cn = -1;
        cs = '0;
        for (int k = 0; k < 3; k++) begin
            if (pk[k] && (cn < 0 || sc[k*32 +: 32] > cs)) begin
                cn = k;
                cs = sc[k*32 +: 32];
            end
        end
        n = seen[m];
        if (win_open[m]) begin
            if (cn >= 0 && cs > best_sc[m]) begin
                best_nid[m] = 2'(cn);
                best_n[m]   = n;
                best_sc[m]  = cs;
            end
            if (n - win_start[m] + 1 == coll_len[m]) model_decide(m, n);
        end else if (n >= next_ok[m] && cn >= 0) begin
            win_open[m]  = 1'b1;
            win_start[m] = n;
            best_nid[m]  = 2'(cn);
            best_n[m]    = n;
            best_sc[m]   = cs;
            if (coll_len[m] == 1) model_decide(m, n);
        end
        seen[m] = n + 1;
    endfunction

    // Called at a negative edge: drive one cycle of input, update the model,
    // then look at busy_o just after the capturing edge.
    task automatic apply_stimulus(input logic v, input logic [2:0] pk, input logic [95:0] sc);
        tvalid = v;
        peak   = pk;
        score  = sc;
        if (v) begin
            model_step(0, pk, sc);
            model_step(1, pk, sc);
        end
        @(posedge clk_i);
        #1;
        chk("busy0", 64'(busy0), 64'(model_busy(0)));
        chk("busy1", 64'(busy1), 64'(model_busy(1)));
        @(negedge clk_i);
    endtask

    task automatic idle_samples(input int count);
        for (int i = 0; i < count; i++) apply_stimulus(1'b1, 3'b000, 96'd0);
    endtask

    task automatic peak_sample(input int det, input logic [31:0] s);
        logic [95:0] sc;
        sc = '0;
        sc[det*32 +: 32] = s;
        apply_stimulus(1'b1, 3'(1 << det), sc);
    endtask

    task automatic check_output(input int m, input logic [1:0] nid, input logic [31:0] idx,
                                input logic [31:0] s);
        chk("decision_seen", 64'(fresh[m]), 64'd1);
        chk("dir_nid", 64'(last_dec[m].nid), 64'(nid));
        chk("dir_idx", 64'(last_dec[m].idx), 64'(idx));
        chk("dir_score", 64'(last_dec[m].score), 64'(s));
        fresh[m] = 1'b0;
    endtask

    // Asserts reset in the middle of the low clock phase and checks that
    // every output clears immediately, without waiting for a clock edge.
    task automatic apply_reset();
        #2;
        chk("pending0_at_reset", 64'(exp_q0.size()), 64'd0);
        chk("pending1_at_reset", 64'(exp_q1.size()), 64'd0);
        reset_i = 1'b1;
        #1;
        chk("rst_valid0", 64'(valid0), 64'd0);
        chk("rst_nid0", 64'(nid0), 64'd0);
        chk("rst_idx0", 64'(idx0), 64'd0);
        chk("rst_score0", 64'(score0), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_valid1", 64'(valid1), 64'd0);
        chk("rst_idx1", 64'(idx1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        model_reset();
        fresh[0] = 1'b0;
        fresh[1] = 1'b0;
        tvalid = 1'b0;
        peak   = '0;
        score  = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    // Scoreboard monitor: every valid_o pulse must match the oldest expected
    // decision of its instance.
    always begin
        dec_t e;
        @(posedge clk_i);
        #1;
        if (!reset_i) begin
            if (valid0) begin
                if (exp_q0.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid0: got nid %0d idx %0d score %0d, expected no decision",
                             nid0, idx0, score0);
                end else begin
                    e = exp_q0.pop_front();
                    chk("nid0", 64'(nid0), 64'(e.nid));
                    chk("idx0", 64'(idx0), 64'(e.idx));
                    chk("score0", 64'(score0), 64'(e.score));
                    last_dec[0].nid   = nid0;
                    last_dec[0].idx   = idx0;
                    last_dec[0].score = score0;
                    fresh[0] = 1'b1;
                end
            end
            if (valid1) begin
                if (exp_q1.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid1: got nid %0d idx %0d score %0d, expected no decision",
                             nid1, idx1, score1);
                end else begin
                    e = exp_q1.pop_front();
                    chk("nid1", 64'(nid1), 64'(e.nid));
                    chk("idx1", 64'(idx1), 64'(e.idx));
                    chk("score1", 64'(score1), 64'(e.score));
                    last_dec[1].nid   = nid1;
                    last_dec[1].idx   = 32'(idx1);
                    last_dec[1].score = score1;
                    fresh[1] = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [2:0]  pk;
        logic [95:0] sc;

        reset_i = 1'b0;
        tvalid  = 1'b0;
        peak    = '0;
        score   = '0;
        model_reset();
        fresh[0] = 1'b0;
        fresh[1] = 1'b0;
        @(negedge clk_i);
        apply_reset();

        // Single detector-1 peak at sample 10; the decision follows sample 25.
        idle_samples(10);
        peak_sample(1, 32'd100);
        idle_samples(14);
        chk("no_early_decision", 64'(fresh[0]), 64'd0);
        idle_samples(1);
        check_output(0, 2'd1, 32'd10, 32'd100);

        // Holdoff covers samples 26..89. The peak at 40 is ignored, and the
        // peak at 90 opens a new window with a 5-cycle strobe gap inside it.
        idle_samples(14);
        peak_sample(0, 32'd999);
        idle_samples(49);
        chk("holdoff_no_decision", 64'(fresh[0]), 64'd0);
        peak_sample(2, 32'd7);
        idle_samples(5);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 3'b111, {3{32'hFFFF_FFFF}});
        idle_samples(10);
        check_output(0, 2'd2, 32'd90, 32'd7);

        // Three peaks in one window; the later equal score does not replace.
        apply_reset();
        idle_samples(10);
        peak_sample(0, 32'd50);
        idle_samples(3);
        peak_sample(2, 32'd80);
        peak_sample(1, 32'd80);
        idle_samples(10);
        check_output(0, 2'd2, 32'd14, 32'd80);

        // Tie within one sample: the lower detector index wins.
        apply_reset();
        idle_samples(5);
        apply_stimulus(1'b1, 3'b011, {32'd0, 32'd70, 32'd70});
        idle_samples(15);
        check_output(0, 2'd0, 32'd5, 32'd70);

        // Reset in the middle of a window discards the decision.
        apply_reset();
        peak_sample(1, 32'd55);
        idle_samples(5);
        apply_reset();
        idle_samples(20);
        chk("no_decision_after_reset", 64'(fresh[0]), 64'd0);
        apply_reset();
        peak_sample(2, 32'd9);
        idle_samples(15);
        check_output(0, 2'd2, 32'd0, 32'd9);

        // Narrow counter: a peak at sample 17 reports index 1.
        apply_reset();
        idle_samples(17);
        peak_sample(1, 32'd3);
        idle_samples(2);
        check_output(1, 2'd1, 32'd1, 32'd3);

        // Randomized traffic with occasional asynchronous resets.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            pk = '0;
            sc = '0;
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 11) == 0) pk[k] = 1'b1;
                sc[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                             : 32'($urandom_range(0, 5));
            end
            apply_stimulus(($urandom_range(0, 3) != 0), pk, sc);
            if ($urandom_range(0, 499) == 0) apply_reset();
        end

        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 3'b000, 96'd0);
        chk("drain_q0", 64'(exp_q0.size()), 64'd0);
        chk("drain_q1", 64'(exp_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
